// File: rtl/stepper_pkg.sv
// Shared types and default constants for the stepper motion-profile stage.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    localparam int CNT_W_DEF        = 24;
    localparam int STEP_W_DEF       = 16;
    localparam int PERIOD_START_DEF = 200000;
    localparam int PERIOD_MIN_DEF   = 20000;
    localparam int ACCEL_DEC_DEF    = 1000;

endpackage

// File: rtl/stepper_ramp_ctrl_if.sv
// Command handshake plus step/dir/status outputs of the ramp controller.
interface stepper_ramp_ctrl_if
    import stepper_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic              abort;
    logic              step_pulse;
    logic              dir;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, abort,
        output cmd_ready, step_pulse, dir, busy, done, steps_left
    );

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, abort,
        input  cmd_ready, step_pulse, dir, busy, done, steps_left
    );
endinterface

// File: rtl/stepper_ramp_ctrl_step_timer.sv
// Free-running step interval timer; strobes pulse_o when the current period elapses.
module step_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             pulse_o
);
    logic [CNT_W-1:0] timer_q;

    // Period only grows mid-interval (abort/decel), so an equality compare never misses.
    assign pulse_o = en_i && (timer_q == period_i - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (clr_i || pulse_o) begin
            timer_q <= '0;
        end else if (en_i) begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal/triangular step-rate ramp feeding the 4-phase phase sequencer.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int STEP_W       = STEP_W_DEF,
    parameter int PERIOD_START = PERIOD_START_DEF,
    parameter int PERIOD_MIN   = PERIOD_MIN_DEF,
    parameter int ACCEL_DEC    = ACCEL_DEC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    stepper_ramp_ctrl_if.slave  bus
);
    localparam logic [CNT_W:0]   START_W = (CNT_W+1)'(PERIOD_START);
    localparam logic [CNT_W:0]   MIN_W   = (CNT_W+1)'(PERIOD_MIN);
    localparam logic [CNT_W:0]   DEC_W   = (CNT_W+1)'(ACCEL_DEC);
    localparam logic [CNT_W-1:0] START_N = CNT_W'(PERIOD_START);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(PERIOD_MIN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [STEP_W-1:0] left_q, left_d;
    logic [STEP_W-1:0] ramp_q, ramp_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;

    logic              pulse, accept, active;
    logic [CNT_W:0]    up_w, dn_w;
    logic [CNT_W-1:0]  per_up, per_dn;
    logic [STEP_W-1:0] left_new, left_src, left_abort, ramp_inc;

    assign active = (state_q != IDLE);
    assign accept = bus.cmd_valid && !active && (bus.cmd_steps != '0);

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept),
        .en_i     (active),
        .period_i (period_q),
        .pulse_o  (pulse)
    );

    // One extra bit so the add/subtract cannot wrap before saturation.
    assign up_w   = {1'b0, period_q} + DEC_W;
    assign dn_w   = {1'b0, period_q} - DEC_W;
    assign per_up = (up_w > START_W) ? START_N : up_w[CNT_W-1:0];
    assign per_dn = (dn_w[CNT_W] || dn_w < MIN_W) ? MIN_N : dn_w[CNT_W-1:0];

    assign left_new   = (left_q == '0) ? '0 : left_q - STEP_W'(1);
    assign left_src   = pulse ? left_new : left_q;
    assign left_abort = (left_src < ramp_q) ? left_src : ramp_q;
    assign ramp_inc   = (ramp_q == '1) ? ramp_q : ramp_q + STEP_W'(1);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        left_d   = left_q;
        ramp_d   = ramp_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.cmd_valid) begin
                if (bus.cmd_steps == '0) begin
                    done_d = 1'b1;
                end else begin
                    dir_d    = bus.cmd_dir;
                    left_d   = bus.cmd_steps;
                    period_d = START_N;
                    ramp_d   = '0;
                    state_d  = ACCEL;
                end
            end
        end else if (bus.abort && state_q != DECEL) begin
            // Any pulse in this cycle is counted first, then the decel budget applied.
            left_d = left_abort;
            if (left_abort == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                period_d = per_up;
                state_d  = DECEL;
            end
        end else if (pulse) begin
            left_d = left_new;
            if (left_new == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (state_q != DECEL && left_new <= ramp_q) begin
                period_d = per_up;
                state_d  = DECEL;
            end else if (state_q == ACCEL) begin
                period_d = per_dn;
                ramp_d   = ramp_inc;
                if (per_dn == MIN_N) state_d = CRUISE;
            end else if (state_q == DECEL) begin
                period_d = per_up;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= START_N;
            left_q   <= '0;
            ramp_q   <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            left_q   <= left_d;
            ramp_q   <= ramp_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

    assign bus.cmd_ready  = !active;
    assign bus.step_pulse = pulse;
    assign bus.dir        = dir_q;
    assign bus.busy       = active;
    assign bus.done       = done_q;
    assign bus.steps_left = left_q;
endmodule
